// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants and types for the JPEG bitstream packer
package jpeg_pkg;
  localparam int ACC_W  = 32;
  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int FILL_W = 6;

  localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;

  typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} pack_state_t;

  function automatic logic [FILL_W-1:0] ceil8(input logic [FILL_W-1:0] f);
    return (f + FILL_W'(7)) & ~FILL_W'(7);
  endfunction
endpackage

// File: rtl/jpeg_byte_stuffer.sv
// rtl/jpeg_byte_stuffer.sv - output byte register with 0xFF->0xFF 0x00 stuffing
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] top_byte,
  input  logic       byte_avail,
  input  logic       out_ready,
  output logic       pop,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       stuff_pending
);
  logic       load_en;
  logic       out_valid_d, out_valid_q;
  logic [7:0] out_byte_d, out_byte_q;
  logic       stuff_d, stuff_q;

  always_comb begin
    load_en     = !out_valid_q || out_ready;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    stuff_d     = stuff_q;
    if (load_en) begin
      // A pending stuff byte always beats fresh accumulator data.
      if (stuff_q) begin
        out_byte_d  = JPEG_STUFF_BYTE;
        out_valid_d = 1'b1;
        stuff_d     = 1'b0;
      end else if (byte_avail) begin
        pop         = 1'b1;
        out_byte_d  = top_byte;
        out_valid_d = 1'b1;
        stuff_d     = (top_byte == JPEG_MARKER_BYTE);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      stuff_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      stuff_q     <= stuff_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_byte      = out_byte_q;
  assign stuff_pending = stuff_q;
endmodule

// File: rtl/jpeg_bitstream_packer.sv
// rtl/jpeg_bitstream_packer.sv - packs Huffman codes MSB-first into a stuffed byte stream
module jpeg_bitstream_packer
  import jpeg_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              flush_done,
  output logic              busy
);
  logic [ACC_W-1:0]  acc_d, acc_q, acc_pop, pad_mask;
  logic [FILL_W-1:0] fill_d, fill_q, fill_pop, fill_up, shift;
  logic [CODE_W-1:0] masked;
  pack_state_t       state_d, state_q;
  logic              flush_done_d, flush_done_q;
  logic              pop, push, stuff_pending;

  jpeg_byte_stuffer u_stuffer (
    .clock         (clock),
    .reset_n       (reset_n),
    .top_byte      (acc_q[ACC_W-1 -: 8]),
    .byte_avail    (fill_q >= FILL_W'(8)),
    .out_ready     (out_ready),
    .pop           (pop),
    .out_valid     (out_valid),
    .out_byte      (out_byte),
    .stuff_pending (stuff_pending)
  );

  always_comb begin
    in_ready = (state_q == RUN) && (fill_q <= FILL_W'(16));
    push     = in_valid && in_ready && (in_len != '0);
    acc_pop  = pop ? (acc_q << 8) : acc_q;
    fill_pop = pop ? (fill_q - FILL_W'(8)) : fill_q;
    masked   = in_code & ~({CODE_W{1'b1}} << in_len);
    // New code lands directly below the bits still held after this cycle's pop.
    shift    = FILL_W'(ACC_W) - fill_pop - {1'b0, in_len};
    fill_up  = ceil8(fill_pop);
    pad_mask = ({ACC_W{1'b1}} >> fill_pop) & ~({ACC_W{1'b1}} >> fill_up);

    acc_d   = acc_pop;
    fill_d  = fill_pop;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (push) begin
          acc_d  = acc_pop | ({{(ACC_W-CODE_W){1'b0}}, masked} << shift);
          fill_d = fill_pop + {1'b0, in_len};
        end
        if (flush) state_d = PAD;
      end
      PAD: begin
        acc_d   = acc_pop | pad_mask;
        fill_d  = fill_up;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (fill_q == '0 && !stuff_pending && (!out_valid || out_ready))
          state_d = DONE;
      end
      DONE: state_d = RUN;
    endcase
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      fill_q       <= '0;
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign flush_done = flush_done_q;
  assign busy       = (fill_q != '0) || stuff_pending || out_valid || (state_q != RUN);
endmodule
